// File: rtl/switch_pkg.sv
// Shared definitions for the AXI Stream switch: arbiter state encoding,
// default port counts shared with mux_unit, and a one-hot to binary helper.
package switch_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int DEFAULT_S_DATA_COUNT = 10;
  localparam int DEFAULT_M_DATA_COUNT = 10;

  // Widest vector the helper below accepts; callers zero-extend into it.
  localparam int MAX_PORTS = 32;
  localparam int MAX_ID_W  = 5;

  function automatic logic [MAX_ID_W-1:0] onehot_to_bin(input logic [MAX_PORTS-1:0] oh);
    logic [MAX_ID_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) bin = bin | MAX_ID_W'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Combinational round-robin find-first: searches the masked request vector
// upward from ptr_i with wrap-around, using a doubled copy of the vector.
module rr_priority_encoder
  import switch_pkg::*;
#(
  parameter int N   = DEFAULT_S_DATA_COUNT,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [N-1:0]   mask_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] idx_o,
  output logic [N-1:0]   onehot_o,
  output logic           found_o
);

  logic [N-1:0]   w_req;
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_hit;

  assign w_req = req_i & ~mask_i;
  assign w_dbl = {w_req, w_req};

  // Scanning from ptr_i through the doubled vector covers every index once.
  always_comb begin
    w_hit   = '0;
    found_o = 1'b0;
    for (int k = 0; k < 2*N; k++) begin
      if (!found_o && (k >= int'(ptr_i)) && w_dbl[k]) begin
        w_hit[k] = 1'b1;
        found_o  = 1'b1;
      end
    end
  end

  assign onehot_o = w_hit[N-1:0] | w_hit[2*N-1:N];
  assign idx_o    = IDW'(onehot_to_bin(MAX_PORTS'(onehot_o)));

  if (N < 2 || N > MAX_PORTS) begin : g_bad_n
    $error("rr_priority_encoder: N out of supported range");
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin packet arbiter for one switch output channel; holds the grant
// until the last beat is accepted. Optional stall watchdog: MUX_ARBITER_WATCHDOG_EN.
module mux_arbiter
  import switch_pkg::*;
#(
  parameter int S_DATA_COUNT   = DEFAULT_S_DATA_COUNT,
  parameter int M_DATA_COUNT   = DEFAULT_M_DATA_COUNT,
  parameter int T_DEST_WIDTH   = $clog2(M_DATA_COUNT),
  parameter int T_ID_WIDTH     = $clog2(S_DATA_COUNT),
  parameter int NUM_CHANNEL    = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                  s_valid_i,
  input  logic [S_DATA_COUNT-1:0]                  s_last_i,
  input  logic                                     m_ready_i,
  output logic [S_DATA_COUNT-1:0]                  grant_o,
  output logic [T_ID_WIDTH-1:0]                    grant_id_o,
  output logic                                     grant_valid_o,
  output logic                                     timeout_o
);

  arb_state_t              r_state;
  logic [S_DATA_COUNT-1:0] r_grant;
  logic [T_ID_WIDTH-1:0]   r_grant_id;
  logic [T_ID_WIDTH-1:0]   r_rr_ptr;
  logic                    r_grant_valid;
  logic                    r_timeout;

  logic [S_DATA_COUNT-1:0] w_req;
  logic [S_DATA_COUNT-1:0] w_win_oh;
  logic [T_ID_WIDTH-1:0]   w_win_id;
  logic [T_ID_WIDTH-1:0]   w_ptr;
  logic [T_ID_WIDTH-1:0]   w_next_ptr;
  logic                    w_found;
  logic                    w_acc;
  logic                    w_done;
  logic                    w_wd_fire;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      w_req[i] = s_valid_i[i] && (int'(s_dest_i[i]) == NUM_CHANNEL)
                 && (int'(s_dest_i[i]) < M_DATA_COUNT);
    end
  end

  assign w_acc      = r_grant_valid && s_valid_i[r_grant_id] && m_ready_i;
  assign w_done     = w_acc && s_last_i[r_grant_id];
  assign w_next_ptr = (r_grant_id == T_ID_WIDTH'(S_DATA_COUNT-1)) ? '0 : r_grant_id + 1'b1;

  // While busy the only arbitration that matters is at packet end, so search
  // from just past the finishing source; r_grant masks it out (zero when idle).
  assign w_ptr = (r_state == ARB_BUSY) ? w_next_ptr : r_rr_ptr;

  rr_priority_encoder #(
    .N   (S_DATA_COUNT),
    .IDW (T_ID_WIDTH)
  ) u_rr_enc (
    .req_i    (w_req),
    .mask_i   (r_grant),
    .ptr_i    (w_ptr),
    .idx_o    (w_win_id),
    .onehot_o (w_win_oh),
    .found_o  (w_found)
  );

`ifdef MUX_ARBITER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            w_stall;

  assign w_stall   = (r_state == ARB_BUSY) && !s_valid_i[r_grant_id];
  assign w_wd_fire = w_stall && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES-1));

  // Idle, valid-high and fresh-grant cycles all leave w_stall low, clearing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (!w_stall || w_wd_fire) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_wd_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ARB_IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_rr_ptr      <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state       <= ARB_BUSY;
            r_grant       <= w_win_oh;
            r_grant_id    <= w_win_id;
            r_grant_valid <= 1'b1;
          end
        end
        ARB_BUSY: begin
          if (w_done || w_wd_fire) begin
            r_rr_ptr  <= w_next_ptr;
            r_timeout <= w_wd_fire;
            if (w_done && w_found) begin
              r_grant    <= w_win_oh;
              r_grant_id <= w_win_id;
            end else begin
              r_state       <= ARB_IDLE;
              r_grant       <= '0;
              r_grant_id    <= '0;
              r_grant_valid <= 1'b0;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign grant_o       = r_grant;
  assign grant_id_o    = r_grant_id;
  assign grant_valid_o = r_grant_valid;
  assign timeout_o     = r_timeout;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mux_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin packet arbiter for one output channel of the AXI Stream switch. It watches all slave ports, selects those whose destination equals this channel, and grants exactly one source at a time. The grant is held for the whole packet, until the beat carrying `last` is accepted downstream. Its grant vector drives the data/last/valid select of `mux_unit` for channel `NUM_CHANNEL`, and its `grant_id_o` becomes that channel's `m_id_o`.

## Interface
Parameters:
- `S_DATA_COUNT`, 10: number of slave (source) ports.
- `M_DATA_COUNT`, 10: number of master channels.
- `T_DEST_WIDTH`, `$clog2(M_DATA_COUNT)`: destination field width.
- `T_ID_WIDTH`, `$clog2(S_DATA_COUNT)`: source index width.
- `NUM_CHANNEL`, 0: index of the channel this arbiter serves.
- `TIMEOUT_CYCLES`, 256: mid-packet starvation limit, used only with the watchdog macro.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `s_dest_i`, in, `[S_DATA_COUNT][T_DEST_WIDTH]`: per-source destination.
- `s_valid_i`, in, `[S_DATA_COUNT]`: per-source valid.
- `s_last_i`, in, `[S_DATA_COUNT]`: per-source last.
- `m_ready_i`, in, 1: downstream ready for this channel.
- `grant_o`, out, `[S_DATA_COUNT]`: one-hot grant; all zero when idle.
- `grant_id_o`, out, `T_ID_WIDTH`: binary index of the granted source.
- `grant_valid_o`, out, 1: a grant is active.
- `timeout_o`, out, 1: one-cycle pulse when a grant is forcibly released.

## Operation
- Request: `req[i] = s_valid_i[i] && (s_dest_i[i] == NUM_CHANNEL)`.
  - Dest is sampled only at arbitration; it is ignored mid-packet.
  - Dest values ≥ `M_DATA_COUNT` never match.
- Beat accept: `acc = grant_valid_o && s_valid_i[grant_id_o] && m_ready_i`.
- State IDLE, `grant_valid_o = 0`:
  - If any `req` is set, pick the first set index searching upward from `rr_ptr` with wrap-around. Load the grant and go to BUSY.
  - With no requests, stay in IDLE.
- State BUSY:
  - On `acc && s_last_i[grant_id_o]`, re-arbitrate in the same cycle. The current source is masked out, because its valid belongs to the finishing beat.
    - If another source requests, load the new grant directly and stay in BUSY, with no bubble.
    - Otherwise go to IDLE.
  - In both cases `rr_ptr` becomes `(winner+1) mod S_DATA_COUNT`, where winner is the source just finished.
- `rr_ptr` advances only on packet completion or timeout, never on single beats.
- The grant never changes mid-packet.

## Timing
- Reset values: `grant_o=0`, `grant_id_o=0`, `grant_valid_o=0`, `timeout_o=0`, `rr_ptr=0`, state IDLE, watchdog counter 0.
- All outputs are registered.
- Request-to-grant latency is 1 cycle: a request seen in IDLE at edge N gives `grant_valid_o=1` after edge N+1.
  - The first beat may be accepted in that first grant cycle.
- Back-to-back packets from different sources: the new grant is visible the cycle after the last-beat accept, with zero idle cycles.
- Same source sending consecutive packets: one IDLE cycle between packets.
- Single-beat packet (`last` on the first beat): the grant lasts exactly one cycle if `m_ready_i=1`.
- `m_ready_i` low holds the grant indefinitely and does not advance the watchdog.
- Reset asserted mid-packet: all state clears on that edge and the packet in flight is abandoned.

## Configuration
- Macro: `MUX_ARBITER_WATCHDOG_EN`.
- With the macro defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` counts BUSY cycles in which `s_valid_i[grant_id_o]=0`.
  - It clears on any cycle where that valid is 1, and on every new grant.
  - When it reaches `TIMEOUT_CYCLES`: `timeout_o` pulses for 1 cycle, the grant drops to IDLE, and `rr_ptr = grant_id_o+1`.
- Without the macro:
  - There is no counter and `timeout_o` is tied to 0.
  - A stalled source holds the channel forever.

## Structure
- Shared package `switch_pkg` holds:
  - the arbiter state enum (IDLE, BUSY);
  - a one-hot-to-binary function;
  - default width constants shared with `mux_unit`.
- Sub-module `rr_priority_encoder` is purely combinational:
  - Inputs: request vector, mask, pointer.
  - Outputs: winner index and found flag.
  - Implemented as a double-width vector with a find-first.
- FSM, registers and watchdog stay in `mux_arbiter`.

## Test plan
- **Reset:** hold `reset=1` for 10 cycles while sources 2 and 5 request. Required: all outputs stay 0. After release, `grant_id_o=2` one cycle later.
- **Round-robin, equal load:** sources 1, 4 and 7 each send continuous 3-beat packets to channel 0 with `m_ready_i=1`. Required: grant order 1, 4, 7, 1, 4, 7…, each grant exactly 3 cycles, with no gap between packets.
- **Dest filter:** source 3 has dest 5 and source 6 has dest 0, with `NUM_CHANNEL=0`. Required: only source 6 is granted. Changing source 6's dest mid-packet does not drop the grant.
- **Backpressure:** source 0 sends 4 beats while `m_ready_i` toggles 1,0,0,1,… Required: the grant is held until the 4th accepted beat, and `timeout_o` stays 0.
- **Single-beat and reset mid-packet:** source 9 sends a 1-beat packet, giving a 1-cycle grant and `rr_ptr=0`. Then source 2 starts a 5-beat packet and `reset=1` is asserted at beat 2. Required: outputs are 0 on the next cycle.
- **Watchdog (macro defined, `TIMEOUT_CYCLES=8`):** source 5 is granted, sends 1 beat, then drops valid. Required: `timeout_o` pulses 8 cycles later, `grant_valid_o` goes to 0, and the next grant favours source 6 over source 5.
